delay_tap_controller: RTL and testbench
=======================================

Name: delay_tap_controller

Overview:
- Command-side controller for the 9-bit variable-load delay-line interface (the `delay__load` / `delay__value` pair).
- Accepts absolute-load, increment and decrement requests over a valid/ready handshake.
- Tracks the current tap value, saturates it to 0..511, drives the load strobe for a fixed time, and waits a settle interval before acknowledging.
- Sits between calibration logic and one or more delay pairs that share the same load interface.

Parameters:
- LOAD_CYCLES, 1, number of cycles `delay__load` is held high per update; legal range 1..15.
- SETTLE_CYCLES, 16, cycles waited after `delay__load` falls before the response; legal range 0..255.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  a request is presented.
- req_ready  output  1  controller can accept a request.
- req_op  input  2  00 load absolute, 01 increment, 10 decrement, 11 re-apply current value.
- req_value  input  9  absolute tap for load; step size for increment/decrement; ignored for re-apply.
- resp_valid  output  1  single-cycle pulse when the update is complete.
- resp_value  output  9  tap value now in effect; valid while resp_valid is high.
- resp_saturated  output  1  the increment or decrement was clamped; valid with resp_valid.
- busy  output  1  high in any state other than IDLE.
- current_value  output  9  registered tap value currently applied.
- delay__load  output  1  load strobe to the delay pair.
- delay__value  output  9  tap value to the delay pair.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state is IDLE.
  - current_value, delay__value and resp_value are 0.
  - delay__load, resp_valid, resp_saturated and busy are 0.
  - req_ready is 1.
- Reset mid-operation aborts immediately: delay__load drops, the value returns to 0, and no response is issued.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, compute the new value, register it into current_value/delay__value, and go to LOAD.
  - LOAD: delay__load=1 for exactly LOAD_CYCLES cycles (counter), then go to SETTLE, or to DONE if SETTLE_CYCLES==0.
  - SETTLE: delay__load=0; count SETTLE_CYCLES cycles, then go to DONE.
  - DONE: resp_valid=1 for one cycle, then go to IDLE.
- req_ready is 0 in LOAD, SETTLE and DONE. A request presented while busy is not consumed; the requester must hold req_valid until accepted.
- Arithmetic is done at 10 bits:
  - Increment: new = min(cur + step, 511); resp_saturated=1 if cur + step > 511.
  - Decrement: new = max(cur − step, 0); resp_saturated=1 if step > cur.
  - Load and re-apply: resp_saturated=0.
  - A step of 0 is legal and still performs a full load/settle cycle.
- delay__value changes only on request acceptance and is stable through LOAD, SETTLE and thereafter.
- Latency, with acceptance at edge N:
  - delay__load is high in cycles N+1 .. N+LOAD_CYCLES.
  - resp_valid is high in cycle N+LOAD_CYCLES+SETTLE_CYCLES+1.
  - req_ready is high again in cycle N+LOAD_CYCLES+SETTLE_CYCLES+2.
  - Defaults: resp at N+18, next accept possible at N+19.
- resp_value equals current_value during resp_valid.
- resp_saturated holds its value until the next acceptance.
- Back-to-back requests: a new request held valid during DONE is accepted in the first IDLE cycle. There are no idle gaps beyond that single cycle.

Test Plan:
- Reset then load 200, defaults:
  - delay__value=200 from cycle N+1.
  - delay__load high only in N+1.
  - resp_valid at N+18 with resp_value=200, resp_saturated=0.
- Current 500, increment step 20: delay__value=511, resp_saturated=1. Then decrement step 11: value 500, resp_saturated=0.
- Current 5, decrement step 9: value 0, resp_saturated=1. Then increment step 0: value 0, full 18-cycle sequence still runs.
- Hold req_valid continuously with load 10 then load 300:
  - The second request is accepted only at N+19.
  - delay__value stays 10 until then.
  - Exactly two resp_valid pulses are seen.
- LOAD_CYCLES=3, SETTLE_CYCLES=0, load 77: delay__load high for N+1..N+3, resp_valid at N+4.
- Assert reset_n low during SETTLE after load 400:
  - delay__load=0 and delay__value=0 immediately.
  - No resp_valid is seen.
  - req_ready=1 after release.

Source files
------------

// File: rtl/delay_tap_controller.sv
// Command-side controller for a 9-bit variable-load delay line: accepts load/inc/dec/re-apply
// requests, saturates the tap to 0..511, strobes the load line, then waits a settle interval.
module delay_tap_controller #(
    parameter int unsigned LOAD_CYCLES   = 1,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [8:0] req_value,
    output logic       resp_valid,
    output logic [8:0] resp_value,
    output logic       resp_saturated,
    output logic       busy,
    output logic [8:0] current_value,
    output logic       delay__load,
    output logic [8:0] delay__value
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        DONE
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [7:0] LOAD_LAST   = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] value_q, value_d;
    logic       sat_q, sat_d;

    logic [9:0] sum;
    logic [8:0] new_value;
    logic       new_sat;

    // Candidate tap for the presented request; the 10-bit sum exposes overflow past 511.
    always_comb begin
        sum       = {1'b0, value_q} + {1'b0, req_value};
        new_value = value_q;
        new_sat   = 1'b0;
        case (req_op)
            OP_LOAD: new_value = req_value;
            OP_INC: begin
                if (sum[9]) begin
                    new_value = 9'd511;
                    new_sat   = 1'b1;
                end else begin
                    new_value = sum[8:0];
                end
            end
            OP_DEC: begin
                if (req_value > value_q) begin
                    new_value = 9'd0;
                    new_sat   = 1'b1;
                end else begin
                    new_value = value_q - req_value;
                end
            end
            default: new_value = value_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    value_d = new_value;
                    sat_d   = new_sat;
                    cnt_d   = 8'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            value_q <= 9'd0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            sat_q   <= sat_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign delay__load    = (state_q == LOAD);
    assign resp_valid     = (state_q == DONE);
    assign resp_value     = value_q;
    assign resp_saturated = sat_q;
    assign current_value  = value_q;
    assign delay__value   = value_q;

endmodule

// File: tb/tb_delay_tap_controller.sv
// Self-checking bench for delay_tap_controller: scoreboard of expected responses plus
// per-scenario cycle checks on a default instance and a short-timing instance.
module tb_delay_tap_controller;

    typedef struct {
        logic [8:0] val;
        logic       sat;
        int         cyc;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [8:0] req_value = 9'd0;
    logic       req_ready, resp_valid, resp_saturated, busy, delay__load;
    logic [8:0] resp_value, current_value, delay__value;

    logic       v3 = 1'b0;
    logic [1:0] op3 = 2'b00;
    logic [8:0] val3 = 9'd0;
    logic       ready3, rv3, rsat3, busy3, load3;
    logic [8:0] rval3, cur3, dval3;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   model_cur = 0;
    rsp_t exp_q[$];
    rsp_t obs_q[$];
    rsp_t mon_e, mon_o;
    int   mon_nv;
    bit   mon_s;

    delay_tap_controller dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_value(req_value), .resp_valid(resp_valid),
        .resp_value(resp_value), .resp_saturated(resp_saturated), .busy(busy),
        .current_value(current_value), .delay__load(delay__load), .delay__value(delay__value)
    );

    delay_tap_controller #(.LOAD_CYCLES(3), .SETTLE_CYCLES(0)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_valid(v3), .req_ready(ready3),
        .req_op(op3), .req_value(val3), .resp_valid(rv3),
        .resp_value(rval3), .resp_saturated(rsat3), .busy(busy3),
        .current_value(cur3), .delay__load(load3), .delay__value(dval3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard producer/collector for the default instance (LOAD 1, SETTLE 16).
    always @(negedge clk) begin
        if (!reset_n) begin
            model_cur = 0;
            exp_q.delete();
        end else begin
            if (req_valid && req_ready) begin
                mon_s = 1'b0;
                case (req_op)
                    2'b00: mon_nv = int'(req_value);
                    2'b01: begin
                        mon_nv = model_cur + int'(req_value);
                        if (mon_nv > 511) begin mon_nv = 511; mon_s = 1'b1; end
                    end
                    2'b10: begin
                        mon_nv = model_cur - int'(req_value);
                        if (mon_nv < 0) begin mon_nv = 0; mon_s = 1'b1; end
                    end
                    default: mon_nv = model_cur;
                endcase
                model_cur = mon_nv;
                mon_e.val = 9'(mon_nv);
                mon_e.sat = mon_s;
                mon_e.cyc = cyc + 1 + 1 + 16;
                exp_q.push_back(mon_e);
            end
            if (resp_valid) begin
                mon_o.val = resp_value;
                mon_o.sat = resp_saturated;
                mon_o.cyc = cyc;
                obs_q.push_back(mon_o);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [8:0] v, output int acc, output bit ok);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_value = v;
        ok = 1'b0; acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (ok) acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (current_value !== 9'd0) begin errors++; $display("FAIL reset_cur got %0d want 0", current_value); end
        checks++; if (delay__value !== 9'd0) begin errors++; $display("FAIL reset_dval got %0d want 0", delay__value); end
        checks++; if (resp_value !== 9'd0) begin errors++; $display("FAIL reset_rval got %0d want 0", resp_value); end
        checks++; if ({delay__load, resp_valid, resp_saturated, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {delay__load, resp_valid, resp_saturated, busy}); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL release_ready got ready=%b busy=%b want 1/0", req_ready, busy); end
        $display("reset: done");
    endtask

    task automatic test_load;
        int acc; bit ok; rsp_t e, o;
        send(2'b00, 9'd200, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_accept got timeout want accept"); end
        @(negedge clk);
        checks++; if (delay__value !== 9'd200 || delay__load !== 1'b1) begin
            errors++; $display("FAIL load_n1 got val=%0d load=%b want 200/1", delay__value, delay__load); end
        @(negedge clk);
        checks++; if (delay__load !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL load_n2 got load=%b busy=%b want 0/1", delay__load, busy); end
        repeat (25) @(negedge clk);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL load_count got %0d want 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.val !== e.val || o.sat !== e.sat || o.cyc != e.cyc || o.cyc != acc + 17) begin
                errors++; $display("FAIL load_resp got %0d/%b@%0d want %0d/%b@%0d", o.val, o.sat, o.cyc, e.val, e.sat, e.cyc); end
            $display("load: resp value=%0d sat=%b cycle=%0d", o.val, o.sat, o.cyc);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturate;
        int acc; bit ok; rsp_t e, o;
        send(2'b00, 9'd500, acc, ok);
        send(2'b01, 9'd20, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inc_accept got timeout want accept"); end
        @(negedge clk);
        checks++; if (delay__value !== 9'd511) begin errors++; $display("FAIL inc_dval got %0d want 511", delay__value); end
        send(2'b10, 9'd11, acc, ok);
        repeat (25) @(negedge clk);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL sat_count got %0d want 3", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.val !== e.val || o.sat !== e.sat || o.cyc != e.cyc) begin
                errors++; $display("FAIL sat_resp got %0d/%b@%0d want %0d/%b@%0d", o.val, o.sat, o.cyc, e.val, e.sat, e.cyc); end
            $display("saturate: resp value=%0d sat=%b cycle=%0d", o.val, o.sat, o.cyc);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_underflow;
        int acc; bit ok; rsp_t e, o;
        send(2'b00, 9'd5, acc, ok);
        send(2'b10, 9'd9, acc, ok);
        repeat (25) @(negedge clk);
        checks++; if (resp_saturated !== 1'b1 || current_value !== 9'd0) begin
            errors++; $display("FAIL dec_hold got sat=%b cur=%0d want 1/0", resp_saturated, current_value); end
        send(2'b01, 9'd0, acc, ok);
        repeat (25) @(negedge clk);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL under_count got %0d want 3", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.val !== e.val || o.sat !== e.sat || o.cyc != e.cyc) begin
                errors++; $display("FAIL under_resp got %0d/%b@%0d want %0d/%b@%0d", o.val, o.sat, o.cyc, e.val, e.sat, e.cyc); end
            $display("underflow: resp value=%0d sat=%b cycle=%0d", o.val, o.sat, o.cyc);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        int acc1, acc2, bad; rsp_t e, o;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b00; req_value = 9'd10;
        acc1 = -1; acc2 = -1; bad = 0;
        for (int i = 0; i < 50 && acc1 < 0; i++) begin
            @(negedge clk);
            if (req_ready) begin @(posedge clk); #1; acc1 = cyc; req_value = 9'd300; end
        end
        for (int i = 0; i < 50 && acc2 < 0; i++) begin
            @(negedge clk);
            if (req_ready) begin @(posedge clk); #1; acc2 = cyc; end
            else if (delay__value !== 9'd10) bad++;
        end
        req_valid = 1'b0;
        checks++; if (acc1 < 0 || acc2 != acc1 + 19) begin
            errors++; $display("FAIL b2b_accept got %0d want %0d", acc2 - acc1, 19); end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_hold got %0d bad cycles want 0", bad); end
        repeat (25) @(negedge clk);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.val !== e.val || o.sat !== e.sat || o.cyc != e.cyc) begin
                errors++; $display("FAIL b2b_resp got %0d/%b@%0d want %0d/%b@%0d", o.val, o.sat, o.cyc, e.val, e.sat, e.cyc); end
            $display("back_to_back: resp value=%0d sat=%b cycle=%0d", o.val, o.sat, o.cyc);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_short_timing;
        logic [5:0] loads, resps;
        logic [8:0] rv_seen;
        bit ok;
        @(posedge clk); #1;
        v3 = 1'b1; op3 = 2'b00; val3 = 9'd77;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ready3) ok = 1'b1;
        end
        @(posedge clk); #1;
        v3 = 1'b0;
        loads = '0; resps = '0; rv_seen = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            loads[k] = load3;
            resps[k] = rv3;
            if (rv3) rv_seen = rval3;
        end
        checks++; if (!ok || loads !== 6'b000111) begin errors++; $display("FAIL short_load got %b want 000111", loads); end
        checks++; if (resps !== 6'b001000) begin errors++; $display("FAIL short_resp got %b want 001000", resps); end
        checks++; if (rv_seen !== 9'd77 || dval3 !== 9'd77) begin
            errors++; $display("FAIL short_value got %0d/%0d want 77", rv_seen, dval3); end
        $display("short_timing: loads=%b resps=%b value=%0d", loads, resps, rv_seen);
    endtask

    task automatic test_reset_mid;
        int acc; bit ok;
        send(2'b00, 9'd400, acc, ok);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || delay__load !== 1'b0 || delay__value !== 9'd400) begin
            errors++; $display("FAIL mid_settle got busy=%b load=%b val=%0d want 1/0/400", busy, delay__load, delay__value); end
        reset_n = 1'b0;
        #1;
        checks++; if (delay__load !== 1'b0 || delay__value !== 9'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_abort got load=%b val=%0d busy=%b want 0/0/0", delay__load, delay__value, busy); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", req_ready); end
        repeat (25) @(negedge clk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_noresp got %0d want 0", obs_q.size()); end
        $display("reset_mid: responses after abort=%0d", obs_q.size());
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_load();
        test_saturate();
        test_underflow();
        test_back_to_back();
        test_short_timing();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
